muldiv_unit: RTL and testbench

- Iterative multiply/divide engine for the execute stage. It replaces single-cycle combinational multiplication with a parametrised multi-cycle unit.
- Supports signed/unsigned MULT, DIV, MADD and MSUB, with a stall handshake to the pipeline.
- Results are delivered as a HI/LO pair for the HILO write path.
- Sits beside the ALU. The execute stage drives start/op/operands and forwarded HI/LO (as accumulator), and routes pause into the pipeline stall controller.

---
 rtl/muldiv_pkg.sv | 42 ++++
 rtl/muldiv_step.sv | 46 ++++
 rtl/muldiv_unit.sv | 208 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Contents: operation codes, FSM state encoding, op-decode helpers.
package muldiv_pkg;

   localparam int unsigned OP_W = 3;

   // Bit0 set = unsigned variant
   typedef enum logic [OP_W-1:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MADD  = 3'd4,
      OP_MADDU = 3'd5,
      OP_MSUB  = 3'd6,
      OP_MSUBU = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   function automatic logic is_div(input logic [OP_W-1:0] op);
      return (op[2:1] == 2'b01);
   endfunction

   function automatic logic is_unsigned(input logic [OP_W-1:0] op);
      return op[0];
   endfunction

   function automatic logic is_acc(input logic [OP_W-1:0] op);
      return op[2];
   endfunction

   function automatic logic is_sub(input logic [OP_W-1:0] op);
      return (op[2:1] == 2'b11);
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide engine (purely combinational).
// Multiply: {hi,lo} holds partial product / remaining multiplier bits; one
//           shift-add step using multiplicand i_b.
// Divide:   hi holds partial remainder, lo holds dividend shifting into
//           quotient; one restoring trial-subtract step against divisor i_b.
// Ports: i_is_div selects the step type; i_hi/i_lo current working pair;
//        i_b multiplicand or divisor; o_hi/o_lo next working pair.
module muldiv_step #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             i_is_div,
   input  logic [WIDTH-1:0] i_hi,
   input  logic [WIDTH-1:0] i_lo,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo
);

   logic [WIDTH:0] w_sum;
   logic [WIDTH:0] w_shift;
   logic [WIDTH:0] w_diff;

   always_comb begin
      // Carry out of the add lands in hi[MSB] after the right shift
      w_sum   = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_b} : '0);
      w_shift = {i_hi, i_lo[WIDTH-1]};
      // Remainder stays below the divisor, so bit WIDTH of the
      // difference is a clean borrow flag
      w_diff  = w_shift - {1'b0, i_b};
      o_hi    = '0;
      o_lo    = '0;
      if (i_is_div) begin
         if (!w_diff[WIDTH]) begin
            o_hi = w_diff[WIDTH-1:0];
            o_lo = {i_lo[WIDTH-2:0], 1'b1};
         end else begin
            o_hi = w_shift[WIDTH-1:0];
            o_lo = {i_lo[WIDTH-2:0], 1'b0};
         end
      end else begin
         o_hi = w_sum[WIDTH:1];
         o_lo = {w_sum[0], i_lo[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multi-cycle multiply/divide unit for the execute stage.
// Ports: clk/rst_n clock and async active-low reset; start/op/opa/opb issue
//        request; acc_hi/acc_lo forwarded HI/LO for MADD/MSUB; cancel flushes
//        an in-flight op; pause stall request (combinational); done one-cycle
//        result strobe; hi_out/lo_out registered HI/LO result.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [OP_W-1:0]  op,
   input  logic [WIDTH-1:0] opa,
   input  logic [WIDTH-1:0] opb,
   input  logic [WIDTH-1:0] acc_hi,
   input  logic [WIDTH-1:0] acc_lo,
   input  logic             cancel,
   output logic             pause,
   output logic             done,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out
);

   state_e             r_state;
   state_e             w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_is_div;
   logic               r_is_acc;
   logic               r_is_sub;
   logic               r_sign_a;
   logic               r_neg;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH-1:0]   r_acc_hi;
   logic [WIDTH-1:0]   r_acc_lo;
   logic               r_done;
   logic [WIDTH-1:0]   r_hi_out;
   logic [WIDTH-1:0]   r_lo_out;

   logic               w_accept;
   logic               w_last;
   logic               w_sign_a;
   logic               w_sign_b;
   logic [WIDTH-1:0]   w_abs_a;
   logic [WIDTH-1:0]   w_abs_b;
   logic [WIDTH-1:0]   w_step_hi;
   logic [WIDTH-1:0]   w_step_lo;
   logic [2*WIDTH-1:0] w_prod;
   logic [2*WIDTH-1:0] w_prod_s;
   logic [2*WIDTH-1:0] w_acc;
   logic [WIDTH-1:0]   w_quo;
   logic [WIDTH-1:0]   w_rem;
   logic [WIDTH-1:0]   w_res_hi;
   logic [WIDTH-1:0]   w_res_lo;

   assign done   = r_done;
   assign hi_out = r_hi_out;
   assign lo_out = r_lo_out;

   // Operand conditioning at issue: magnitudes plus sign flags
   always_comb begin
      w_sign_a = !is_unsigned(op) && opa[WIDTH-1];
      w_sign_b = !is_unsigned(op) && opb[WIDTH-1];
      w_abs_a  = w_sign_a ? -opa : opa;
      w_abs_b  = w_sign_b ? -opb : opb;
      w_accept = (r_state == ST_IDLE) && start && !cancel;
      w_last   = (r_cnt == CNT_W'(WIDTH - 1));
   end

   muldiv_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .i_is_div (r_is_div),
      .i_hi     (r_hi),
      .i_lo     (r_lo),
      .i_b      (r_b),
      .o_hi     (w_step_hi),
      .o_lo     (w_step_lo)
   );

   // Sign fix-up and accumulation applied in FIX
   always_comb begin
      w_prod   = {r_hi, r_lo};
      w_prod_s = r_neg ? -w_prod : w_prod;
      w_acc    = {r_acc_hi, r_acc_lo};
      w_quo    = r_neg ? -r_lo : r_lo;
      // Divide by zero leaves |opa| in the remainder, so restoring the
      // dividend's sign reproduces opa exactly
      w_rem    = r_sign_a ? -r_hi : r_hi;
      w_res_hi = '0;
      w_res_lo = '0;
      if (r_is_div) begin
         if (r_b == '0) begin
            w_res_hi = w_rem;
            w_res_lo = '1;
         end else begin
            w_res_hi = w_rem;
            w_res_lo = w_quo;
         end
      end else if (r_is_acc) begin
         if (r_is_sub) begin
            {w_res_hi, w_res_lo} = w_acc - w_prod_s;
         end else begin
            {w_res_hi, w_res_lo} = w_acc + w_prod_s;
         end
      end else begin
         {w_res_hi, w_res_lo} = w_prod_s;
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next state and stall request
   always_comb begin
      w_state_nxt = r_state;
      pause       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_state_nxt = ST_RUN;
               pause       = 1'b1;
            end
         end
         ST_RUN: begin
            pause = 1'b1;
            if (cancel) begin
               w_state_nxt = ST_IDLE;
            end else if (w_last) begin
               w_state_nxt = ST_FIX;
            end
         end
         ST_FIX: begin
            pause       = 1'b1;
            w_state_nxt = cancel ? ST_IDLE : ST_DONE;
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Working registers, iteration counter and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= '0;
         r_is_div <= 1'b0;
         r_is_acc <= 1'b0;
         r_is_sub <= 1'b0;
         r_sign_a <= 1'b0;
         r_neg    <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_b      <= '0;
         r_acc_hi <= '0;
         r_acc_lo <= '0;
         r_done   <= 1'b0;
         r_hi_out <= '0;
         r_lo_out <= '0;
      end else begin
         r_done <= (r_state == ST_FIX) && !cancel;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_cnt    <= '0;
                  r_is_div <= is_div(op);
                  r_is_acc <= is_acc(op);
                  r_is_sub <= is_sub(op);
                  r_sign_a <= w_sign_a;
                  r_neg    <= w_sign_a ^ w_sign_b;
                  r_hi     <= '0;
                  r_lo     <= w_abs_a;
                  r_b      <= w_abs_b;
                  r_acc_hi <= acc_hi;
                  r_acc_lo <= acc_lo;
               end
            end
            ST_RUN: begin
               r_cnt <= r_cnt + CNT_W'(1);
               r_hi  <= w_step_hi;
               r_lo  <= w_step_lo;
            end
            ST_FIX: begin
               if (!cancel) begin
                  r_hi_out <= w_res_hi;
                  r_lo_out <= w_res_lo;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
   import muldiv_pkg::*;

   localparam int unsigned W       = 32;
   localparam int          LATENCY = W + 2;

   logic          clk    = 1'b0;
   logic          rst_n  = 1'b0;
   logic          start  = 1'b0;
   logic [2:0]    op     = 3'd0;
   logic [W-1:0]  opa    = '0;
   logic [W-1:0]  opb    = '0;
   logic [W-1:0]  acc_hi = '0;
   logic [W-1:0]  acc_lo = '0;
   logic          cancel = 1'b0;
   logic          pause;
   logic          done;
   logic [W-1:0]  hi_out;
   logic [W-1:0]  lo_out;

   muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .op     (op),
      .opa    (opa),
      .opb    (opb),
      .acc_hi (acc_hi),
      .acc_lo (acc_lo),
      .cancel (cancel),
      .pause  (pause),
      .done   (done),
      .hi_out (hi_out),
      .lo_out (lo_out)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      int           start_cyc;
   } exp_t;

   exp_t sb_q[$];
   int   errors = 0;
   int   checks = 0;
   logic prev_done = 1'b0;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: plain 64-bit arithmetic on the architectural meaning
   function automatic logic [2*W-1:0] model(input logic [2:0] mop, input logic [W-1:0] a,
                                            input logic [W-1:0] b, input logic [W-1:0] ah,
                                            input logic [W-1:0] al);
      longint       sa, sb, q, r;
      logic [63:0]  ua, ub, p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      case (mop)
         3'd0: p = sa * sb;
         3'd1: p = ua * ub;
         3'd2, 3'd3: begin
            if (b == '0) return {a, 32'hFFFF_FFFF};
            if (mop == 3'd2) begin
               q = sa / sb;
               r = sa % sb;
               return {r[31:0], q[31:0]};
            end
            p = ua / ub;
            return {W'(ua % ub), p[31:0]};
         end
         3'd4: p = {ah, al} + 64'(sa * sb);
         3'd5: p = {ah, al} + ua * ub;
         3'd6: p = {ah, al} - 64'(sa * sb);
         default: p = {ah, al} - ua * ub;
      endcase
      return p;
   endfunction

   // Monitor: pops the scoreboard whenever the DUT presents a result
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (done) begin
            check("done_single_cycle", W'(prev_done), W'(0));
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got hi=%h lo=%h expected no result (cycle %0d)",
                        hi_out, lo_out, cyc);
            end else begin
               e = sb_q.pop_front();
               check("result_hi", hi_out, e.hi);
               check("result_lo", lo_out, e.lo);
               check("latency", W'(cyc - e.start_cyc), W'(LATENCY));
            end
         end
         prev_done = done;
      end else begin
         prev_done = 1'b0;
      end
   end

   task automatic issue(input logic [2:0] mop, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ah, input logic [W-1:0] al, input bit push,
                        output int sc);
      exp_t e;
      logic [2*W-1:0] r;
      @(posedge clk); #1;
      start  = 1'b1;
      op     = mop;
      opa    = a;
      opb    = b;
      acc_hi = ah;
      acc_lo = al;
      sc     = cyc;
      if (push) begin
         r = model(mop, a, b, ah, al);
         e.hi = r[2*W-1:W];
         e.lo = r[W-1:0];
         e.start_cyc = sc;
         sb_q.push_back(e);
      end
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done();
      bit seen = 0;
      for (int i = 0; i < 3 * LATENCY && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got no done expected done within %0d cycles", 3 * LATENCY);
      end
   endtask

   task automatic run_op(input logic [2:0] mop, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] ah, input logic [W-1:0] al);
      int sc;
      issue(mop, a, b, ah, al, 1'b1, sc);
      wait_done();
   endtask

   initial begin
      int sc;
      logic [2:0]   rop;
      logic [W-1:0] ra, rb;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("reset_hi", hi_out, '0);
      check("reset_lo", lo_out, '0);
      check("reset_done", W'(done), '0);
      check("reset_pause", W'(pause), '0);
      rst_n = 1'b1;

      // Signed multiply with cycle-accurate pause profile
      @(posedge clk); #1;
      start = 1'b1; op = OP_MULT; opa = 32'hFFFF_FFFD; opb = 32'd7;
      sc = cyc;
      sb_q.push_back('{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFEB, start_cyc: sc});
      for (int k = 0; k <= LATENCY; k++) begin
         @(negedge clk);
         check($sformatf("pause_c%0d", k), W'(pause), W'(k < LATENCY));
         @(posedge clk); #1;
         start = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      check("hold_hi", hi_out, 32'hFFFF_FFFF);
      check("hold_lo", lo_out, 32'hFFFF_FFEB);

      // Directed cases
      run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '0, '0);
      run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2, '0, '0);
      run_op(OP_DIVU,  32'd5, 32'd0, '0, '0);
      run_op(OP_DIV,   32'hFFFF_FFF9, 32'd0, '0, '0);
      run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, '0, '0);
      run_op(OP_MULT,  32'd0, 32'd0, '0, '0);
      run_op(OP_MADDU, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF);
      run_op(OP_MSUB,  32'd1, 32'd1, 32'd0, 32'd0);

      // start together with cancel in IDLE is dropped
      @(posedge clk); #1;
      start = 1'b1; cancel = 1'b1; op = OP_MULT; opa = 32'd9; opb = 32'd9;
      @(negedge clk);
      check("drop_pause", W'(pause), '0);
      @(posedge clk); #1;
      start = 1'b0; cancel = 1'b0;
      @(negedge clk);
      check("drop_idle_pause", W'(pause), '0);

      // Cancel mid-multiply, then a fresh start two cycles later
      issue(OP_MULT, 32'd3, 32'd5, '0, '0, 1'b0, sc);
      while (cyc < sc + 10) begin
         @(posedge clk); #1;
      end
      cancel = 1'b1;
      @(posedge clk); #1;
      cancel = 1'b0;
      @(negedge clk);
      check("cancel_pause", W'(pause), '0);
      check("cancel_done", W'(done), '0);
      check("cancel_hold_hi", hi_out, 32'hFFFF_FFFF);
      check("cancel_hold_lo", lo_out, 32'hFFFF_FFFF);
      run_op(OP_MULT, 32'd6, 32'hFFFF_FFF9, '0, '0);

      // Reset in the middle of a divide
      issue(OP_DIV, 32'd1000, 32'd7, '0, '0, 1'b1, sc);
      while (cyc < sc + 20) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      check("midrst_hi", hi_out, '0);
      check("midrst_lo", lo_out, '0);
      check("midrst_done", W'(done), '0);
      check("midrst_pause", W'(pause), '0);
      sb_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      run_op(OP_DIVU, 32'd100, 32'd7, '0, '0);

      // Randomised back-to-back traffic
      for (int n = 0; n < 40; n++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
         rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 15));
         run_op(rop, ra, rb, $urandom, $urandom);
      end

      repeat (4) @(negedge clk);
      check("scoreboard_empty", W'(sb_q.size()), '0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
